ysyx_22040210_pht_updq: RTL and testbench

YSYX_22040210_PHT_UPDQ -- requirements
Module: ysyx_22040210_pht_updq

---
 rtl/ysyx_22040210_pht_updq_pkg.sv | 21 ++
 rtl/ysyx_22040210_satcnt2.sv | 22 ++
 rtl/ysyx_22040210_pht_updq.sv | 122 ++++++++++++
 tb/tb_ysyx_22040210_pht_updq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040210_pht_updq_pkg.sv
// Shared widths for the branch predictor, plus the PHT counter encoding
// used by the update queue.

`ifndef YSYX_22040210_DEFINE_V
`define YSYX_22040210_DEFINE_V
`define ysyx_22040210_InstAdderBus 63:0
`define ysyx_22040210_BHRLEN       8
`define ysyx_22040210_UPDQ_DEPTH   4
`endif

package ysyx_22040210_pht_updq_pkg;

  // 2-bit PHT counter: strongly/weakly not-taken, weakly/strongly taken
  typedef enum logic [1:0] {
    PHT_SN = 2'b00,
    PHT_WN = 2'b01,
    PHT_WT = 2'b10,
    PHT_ST = 2'b11
  } pht_state_e;

endpackage

// File: rtl/ysyx_22040210_satcnt2.sv
// 2-bit saturating counter next-state: step toward the actual outcome,
// holding at the rails.

module ysyx_22040210_satcnt2
  import ysyx_22040210_pht_updq_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_nx
);

  // Saturating increment on taken, saturating decrement on not-taken
  always_comb begin
    cnt_nx = cnt;
    if (taken) begin
      if (cnt != PHT_ST) cnt_nx = cnt + 2'd1;
    end else begin
      if (cnt != PHT_SN) cnt_nx = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/ysyx_22040210_pht_updq.sv
// PHT update queue: buffers resolved branch counter updates from commit and
// replays them into gshare one per cycle. Updates that leave the counter
// unchanged are dropped before the queue but still counted.

module ysyx_22040210_pht_updq
  import ysyx_22040210_pht_updq_pkg::*;
#(
  parameter int DEPTH = `ysyx_22040210_UPDQ_DEPTH,
  parameter int PCW   = $bits(logic [`ysyx_22040210_InstAdderBus]),
  parameter int HL    = `ysyx_22040210_BHRLEN
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           upd_valid_i,
  output logic           upd_ready_o,
  input  logic [PCW-1:0] upd_pc_i,
  input  logic [HL-1:0]  upd_bhr_i,
  input  logic [1:0]     upd_pht_i,
  input  logic           upd_taken_i,
  input  logic           upd_mispred_i,
  output logic           gshare_wepht_o,
  output logic [1:0]     gshare_fixpht_o,
  output logic [PCW-1:0] gshare_fixpc_o,
  output logic [HL-1:0]  bpu_fixbhr_o,
  input  logic           perf_clr_i,
  output logic [31:0]    perf_branch_o,
  output logic [31:0]    perf_miss_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PCW-1:0] pc_mem_q  [DEPTH];
  logic [HL-1:0]  bhr_mem_q [DEPTH];
  logic [1:0]     pht_mem_q [DEPTH];

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    perf_branch_q, perf_branch_d;
  logic [31:0]    perf_miss_q, perf_miss_d;

  logic [1:0]     cnt_nx;
  logic           accept;
  logic           push;
  logic           pop;

  ysyx_22040210_satcnt2 u_satcnt2 (
    .cnt    (upd_pht_i),
    .taken  (upd_taken_i),
    .cnt_nx (cnt_nx)
  );

  // Ready comes from the registered count only, so a pop this cycle does
  // not open a slot until the next one.
  assign upd_ready_o = (cnt_q < CW'(DEPTH));
  assign accept      = upd_valid_i && upd_ready_o;
  assign push        = accept && (cnt_nx != upd_pht_i);
  assign pop         = (cnt_q != '0);

  // Pointer, occupancy and perf-counter next state
  always_comb begin
    wr_ptr_d      = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d         = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
    perf_branch_d = perf_branch_q;
    perf_miss_d   = perf_miss_q;
    if (perf_clr_i) begin
      perf_branch_d = '0;
      perf_miss_d   = '0;
    end else if (accept) begin
      perf_branch_d = perf_branch_q + 32'd1;
      if (upd_mispred_i) perf_miss_d = perf_miss_q + 32'd1;
    end
  end

  // Control state register with async active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      perf_branch_q <= '0;
      perf_miss_q   <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      perf_branch_q <= perf_branch_d;
      perf_miss_q   <= perf_miss_d;
    end
  end

  // Payload storage needs no reset: it is only visible while count is nonzero
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]  <= upd_pc_i;
      bhr_mem_q[wr_ptr_q] <= upd_bhr_i;
      pht_mem_q[wr_ptr_q] <= cnt_nx;
    end
  end

  // Head entry drives the PHT write port; outputs are zero when empty
  always_comb begin
    gshare_wepht_o  = 1'b0;
    gshare_fixpht_o = '0;
    gshare_fixpc_o  = '0;
    bpu_fixbhr_o    = '0;
    if (pop) begin
      gshare_wepht_o  = 1'b1;
      gshare_fixpht_o = pht_mem_q[rd_ptr_q];
      gshare_fixpc_o  = pc_mem_q[rd_ptr_q];
      bpu_fixbhr_o    = bhr_mem_q[rd_ptr_q];
    end
  end

  assign perf_branch_o = perf_branch_q;
  assign perf_miss_o   = perf_miss_q;

endmodule

// File: tb/tb_ysyx_22040210_pht_updq.sv
// Directed bench for the PHT update queue.

module tb_ysyx_22040210_pht_updq;

  localparam int DEPTH = 4;
  localparam int PCW   = 64;
  localparam int HL    = 8;

  logic           clk;
  logic           rst;
  logic           upd_valid_i;
  logic           upd_ready_o;
  logic [PCW-1:0] upd_pc_i;
  logic [HL-1:0]  upd_bhr_i;
  logic [1:0]     upd_pht_i;
  logic           upd_taken_i;
  logic           upd_mispred_i;
  logic           gshare_wepht_o;
  logic [1:0]     gshare_fixpht_o;
  logic [PCW-1:0] gshare_fixpc_o;
  logic [HL-1:0]  bpu_fixbhr_o;
  logic           perf_clr_i;
  logic [31:0]    perf_branch_o;
  logic [31:0]    perf_miss_o;

  int n_cmp;
  int n_err;

  logic [1:0] v_pht [5];
  logic       v_tk  [5];
  logic [1:0] v_exp [5];

  ysyx_22040210_pht_updq #(
    .DEPTH (DEPTH),
    .PCW   (PCW),
    .HL    (HL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .upd_valid_i     (upd_valid_i),
    .upd_ready_o     (upd_ready_o),
    .upd_pc_i        (upd_pc_i),
    .upd_bhr_i       (upd_bhr_i),
    .upd_pht_i       (upd_pht_i),
    .upd_taken_i     (upd_taken_i),
    .upd_mispred_i   (upd_mispred_i),
    .gshare_wepht_o  (gshare_wepht_o),
    .gshare_fixpht_o (gshare_fixpht_o),
    .gshare_fixpc_o  (gshare_fixpc_o),
    .bpu_fixbhr_o    (bpu_fixbhr_o),
    .perf_clr_i      (perf_clr_i),
    .perf_branch_o   (perf_branch_o),
    .perf_miss_o     (perf_miss_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_upd(input logic [63:0] pc, input logic [7:0] bhr, input logic [1:0] pht,
                           input logic tk, input logic mp);
    upd_valid_i   = 1'b1;
    upd_pc_i      = pc;
    upd_bhr_i     = bhr;
    upd_pht_i     = pht;
    upd_taken_i   = tk;
    upd_mispred_i = mp;
  endtask

  task automatic idle();
    upd_valid_i   = 1'b0;
    upd_pc_i      = '0;
    upd_bhr_i     = '0;
    upd_pht_i     = '0;
    upd_taken_i   = 1'b0;
    upd_mispred_i = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    // Each update moves the counter one step, so every one is enqueued
    v_pht[0] = 2'd0; v_tk[0] = 1'b1; v_exp[0] = 2'd1;
    v_pht[1] = 2'd1; v_tk[1] = 1'b1; v_exp[1] = 2'd2;
    v_pht[2] = 2'd2; v_tk[2] = 1'b0; v_exp[2] = 2'd1;
    v_pht[3] = 2'd3; v_tk[3] = 1'b0; v_exp[3] = 2'd2;
    v_pht[4] = 2'd2; v_tk[4] = 1'b1; v_exp[4] = 2'd3;

    rst        = 1'b0;
    perf_clr_i = 1'b0;
    idle();

    // Reset state
    #2;
    check_val("rst_ready", upd_ready_o, 1);
    check_val("rst_wepht", gshare_wepht_o, 0);
    check_val("rst_branch", perf_branch_o, 0);
    check_val("rst_miss", perf_miss_o, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single update, one-cycle latency
    drive_upd(64'h8000_0010, 8'h00, 2'b01, 1'b1, 1'b0);
    check_val("t1_same_cycle", gshare_wepht_o, 0);
    tick();
    idle();
    check_val("t1_wepht", gshare_wepht_o, 1);
    check_val("t1_fixpht", gshare_fixpht_o, 2'b10);
    check_val("t1_fixpc", gshare_fixpc_o, 64'h8000_0010);
    check_val("t1_fixbhr", bpu_fixbhr_o, 0);
    check_val("t1_branch", perf_branch_o, 1);
    tick();
    check_val("t1_wepht_off", gshare_wepht_o, 0);
    check_val("t1_fixpc_off", gshare_fixpc_o, 0);
    check_val("t1_fixpht_off", gshare_fixpht_o, 0);

    // Silent updates at both rails
    perf_clr_i = 1'b1;
    tick();
    perf_clr_i = 1'b0;
    check_val("t2_clr_branch", perf_branch_o, 0);
    drive_upd(64'h8000_0020, 8'h11, 2'b11, 1'b1, 1'b0);
    tick();
    check_val("t2_wepht_a", gshare_wepht_o, 0);
    drive_upd(64'h8000_0024, 8'h12, 2'b00, 1'b0, 1'b0);
    tick();
    idle();
    check_val("t2_wepht_b", gshare_wepht_o, 0);
    tick();
    check_val("t2_wepht_c", gshare_wepht_o, 0);
    check_val("t2_branch", perf_branch_o, 2);

    // Five consecutive changing updates drain in order
    for (int i = 0; i < 5; i++) begin
      drive_upd(64'h1000 + 64'(4 * i), 8'(i), v_pht[i], v_tk[i], 1'b0);
      check_val("t3_ready", upd_ready_o, 1);
      tick();
      check_val("t3_wepht", gshare_wepht_o, 1);
      check_val("t3_fixpc", gshare_fixpc_o, 64'h1000 + 64'(4 * i));
      check_val("t3_fixpht", gshare_fixpht_o, v_exp[i]);
      check_val("t3_fixbhr", bpu_fixbhr_o, 8'(i));
    end
    idle();
    tick();
    check_val("t3_drained", gshare_wepht_o, 0);
    check_val("t3_branch", perf_branch_o, 7);

    // Mispredict counting and clear priority
    drive_upd(64'h4000, 8'h00, 2'b11, 1'b1, 1'b1);
    tick();
    drive_upd(64'h4004, 8'h00, 2'b11, 1'b1, 1'b0);
    tick();
    drive_upd(64'h4008, 8'h00, 2'b11, 1'b1, 1'b1);
    tick();
    idle();
    check_val("t4_branch", perf_branch_o, 10);
    check_val("t4_miss", perf_miss_o, 2);
    drive_upd(64'h400c, 8'h00, 2'b11, 1'b1, 1'b1);
    perf_clr_i = 1'b1;
    tick();
    perf_clr_i = 1'b0;
    idle();
    check_val("t4_clr_branch", perf_branch_o, 0);
    check_val("t4_clr_miss", perf_miss_o, 0);
    drive_upd(64'h4010, 8'h00, 2'b11, 1'b1, 1'b1);
    tick();
    idle();
    check_val("t4_post_branch", perf_branch_o, 1);
    check_val("t4_post_miss", perf_miss_o, 1);

    // Reset while draining discards the pending update
    drive_upd(64'h2000, 8'h21, 2'b00, 1'b1, 1'b0);
    tick();
    check_val("t5_wepht_a", gshare_wepht_o, 1);
    check_val("t5_fixpc_a", gshare_fixpc_o, 64'h2000);
    drive_upd(64'h2004, 8'h22, 2'b01, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_val("t5_rst_wepht", gshare_wepht_o, 0);
    check_val("t5_rst_fixpc", gshare_fixpc_o, 0);
    check_val("t5_rst_ready", upd_ready_o, 1);
    check_val("t5_rst_branch", perf_branch_o, 0);
    idle();
    @(posedge clk);
    #3;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t5_no_write", gshare_wepht_o, 0);
    end

    // Perf counter wrap at 2^32
    force dut.perf_branch_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_branch_q;
    check_val("t6_preset", perf_branch_o, 32'hFFFF_FFFF);
    drive_upd(64'h3000, 8'h00, 2'b11, 1'b1, 1'b0);
    tick();
    idle();
    check_val("t6_wrap", perf_branch_o, 32'h0000_0000);
    tick();
    check_val("t6_hold", perf_branch_o, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
